// File: rtl/tcp_tx_sched_if.sv
// Bundle of the requester-side and encoder-side signals of tcp_tx_sched.
// The scheduler connects through the slave modport; the requesters/encoder drive the master modport.
interface tcp_tx_sched_if #(
    parameter int unsigned NREQ = 3
);
    localparam int unsigned LGW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [8*NREQ-1:0]  req_flags;
    logic [32*NREQ-1:0] req_seq;
    logic [32*NREQ-1:0] req_ack;
    logic [NREQ-1:0]    req_grant;
    logic               enc_en;
    logic [7:0]         enc_flags;
    logic [31:0]        enc_seq;
    logic [31:0]        enc_ack;
    logic               enc_ready;
    logic               enc_done;
    logic               busy;
    logic [LGW-1:0]     last_grant;
    logic               err;

    modport slave (
        input  req_valid, req_flags, req_seq, req_ack, enc_ready, enc_done,
        output req_grant, enc_en, enc_flags, enc_seq, enc_ack, busy, last_grant, err
    );

    modport master (
        output req_valid, req_flags, req_seq, req_ack, enc_ready, enc_done,
        input  req_grant, enc_en, enc_flags, enc_seq, enc_ack, busy, last_grant, err
    );
endinterface

// File: rtl/tcp_tx_sched.sv
// Round-robin TCP segment scheduler: grants one requester, drives the header encoder, enforces an inter-segment gap.
// Define TCP_TX_SCHED_TIMEOUT_EN to add the RUN-state watchdog that raises err and aborts to GAP.
module tcp_tx_sched #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned GAP_CYCLES = 12,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    tcp_tx_sched_if.slave bus_if
);
    localparam int unsigned LGW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || GAP_CYCLES > 255 || TIMEOUT == 0) begin : g_bad_cfg
        $error("tcp_tx_sched: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_e;

    state_e         state_q, state_d;
    logic [LGW-1:0] last_q, last_d;
    logic [7:0]     flags_q, flags_d;
    logic [31:0]    seq_q, seq_d;
    logic [31:0]    ack_q, ack_d;
    logic [7:0]     gap_q, gap_d;
    logic           arm_q;
    logic [LGW-1:0] win;
    logic           win_vld;
    logic           grant_go;

`ifdef TCP_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] run_q, run_d;
    logic          err_q, err_d;
`endif

    function automatic logic [LGW-1:0] rr_idx(input logic [LGW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[LGW-1:0];
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!win_vld && bus_if.req_valid[rr_idx(last_q, k)]) begin
                win     = rr_idx(last_q, k);
                win_vld = 1'b1;
            end
        end
    end

    // arm_q holds off arbitration for the first edge after reset release.
    assign grant_go = (state_q == IDLE) && arm_q && bus_if.enc_ready && win_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= LGW'(NREQ - 1);
            flags_q <= '0;
            seq_q   <= '0;
            ack_q   <= '0;
            gap_q   <= '0;
            arm_q   <= 1'b0;
`ifdef TCP_TX_SCHED_TIMEOUT_EN
            run_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            flags_q <= flags_d;
            seq_q   <= seq_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
            arm_q   <= 1'b1;
`ifdef TCP_TX_SCHED_TIMEOUT_EN
            run_q   <= run_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        flags_d = flags_q;
        seq_d   = seq_q;
        ack_d   = ack_q;
        gap_d   = gap_q;
`ifdef TCP_TX_SCHED_TIMEOUT_EN
        run_d   = run_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_go) begin
                    state_d = START;
                    last_d  = win;
                    flags_d = bus_if.req_flags[8*win +: 8];
                    seq_d   = bus_if.req_seq[32*win +: 32];
                    ack_d   = bus_if.req_ack[32*win +: 32];
`ifdef TCP_TX_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            START: begin
                state_d = RUN;
`ifdef TCP_TX_SCHED_TIMEOUT_EN
                run_d   = '0;
`endif
            end
            RUN: begin
                if (bus_if.enc_done) begin
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    gap_d   = 8'(GAP_CYCLES);
                end
`ifdef TCP_TX_SCHED_TIMEOUT_EN
                else if (run_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    gap_d   = 8'(GAP_CYCLES);
                end else begin
                    run_d = run_q + TW'(1);
                end
`endif
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus_if.req_grant = '0;
        if (state_q == START) bus_if.req_grant[last_q] = 1'b1;
        bus_if.enc_en     = (state_q == RUN);
        bus_if.busy       = (state_q != IDLE);
        bus_if.last_grant = last_q;
        bus_if.enc_flags  = flags_q;
        bus_if.enc_seq    = seq_q;
        bus_if.enc_ack    = ack_q;
`ifdef TCP_TX_SCHED_TIMEOUT_EN
        bus_if.err        = err_q;
`else
        bus_if.err        = 1'b0;
`endif
    end
endmodule

// File: tb/tb_tcp_tx_sched.sv
// Bench for tcp_tx_sched: directed scenarios plus randomized traffic against a cycle-numbered transaction model.
module tb_tcp_tx_sched;
    localparam int NREQ = 3;
    localparam int GAP  = 12;
    localparam int INF  = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcp_tx_sched_if #(.NREQ(NREQ)) bus_if ();

    tcp_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus_if)
    );

    // Model: a segment granted in cycle t_grant runs t_grant+1..t_done, busy until t_done+GAP.
    int n = 0, rel = 0, t_grant = -1000, t_done = -1000, done_at = -1, run_max = 6;
    int m_last = NREQ - 1;
    logic [7:0]  m_flags = '0;
    logic [31:0] m_seq = '0, m_ack = '0;
    logic [NREQ-1:0] pending = '0;
    logic [7:0]  pflags [NREQ];
    logic [31:0] pseq [NREQ];
    logic [31:0] pack [NREQ];
    bit ready_v = 1'b1, stray_en = 1'b0;
    int unsigned glog[$];
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic bit in_busy(input int m);
        return (m >= t_grant) && (m <= t_done + GAP);
    endfunction

    function automatic bit in_run(input int m);
        return (m > t_grant) && (m <= t_done);
    endfunction

    task automatic drive_inputs();
        bus_if.req_valid = pending;
        bus_if.enc_ready = ready_v;
        for (int i = 0; i < NREQ; i++) begin
            bus_if.req_flags[8*i +: 8] = pflags[i];
            bus_if.req_seq[32*i +: 32] = pseq[i];
            bus_if.req_ack[32*i +: 32] = pack[i];
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] eg;
        bit done_v;
        int w;
        @(negedge clk);
        n++;
        eg = '0;
        if (n == t_grant) eg[m_last] = 1'b1;
        check("req_grant", 64'(bus_if.req_grant), 64'(eg));
        check("grant_onehot", 64'($countones(bus_if.req_grant) <= 1), 64'(1));
        if (bus_if.req_grant != '0) glog.push_back(32'(bus_if.req_grant));
        check("enc_en", 64'(bus_if.enc_en), 64'(in_run(n)));
        check("busy", 64'(bus_if.busy), 64'(in_busy(n)));
        check("last_grant", 64'(bus_if.last_grant), 64'(m_last));
        check("enc_flags", 64'(bus_if.enc_flags), 64'(m_flags));
        check("enc_seq", 64'(bus_if.enc_seq), 64'(m_seq));
        check("enc_ack", 64'(bus_if.enc_ack), 64'(m_ack));
        check("err", 64'(bus_if.err), 64'(0));

        done_v = (n == done_at) || (stray_en && !in_run(n) && $urandom_range(0, 7) == 0);
        bus_if.enc_done = done_v;
        drive_inputs();

        if (done_v && in_run(n) && t_done == INF) t_done = n;
        if (!in_busy(n) && n > rel && ready_v && pending != '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && pending[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            m_last  = w;
            m_flags = pflags[w];
            m_seq   = pseq[w];
            m_ack   = pack[w];
            t_grant = n + 1;
            t_done  = INF;
            done_at = t_grant + $urandom_range(1, run_max);
            pending[w] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus_if.enc_done = 1'b0;
        #1;
        check("rst_enc_en", 64'(bus_if.enc_en), 64'(0));
        check("rst_busy", 64'(bus_if.busy), 64'(0));
        check("rst_grant", 64'(bus_if.req_grant), 64'(0));
        check("rst_err", 64'(bus_if.err), 64'(0));
        check("rst_last_grant", 64'(bus_if.last_grant), 64'(NREQ - 1));
        check("rst_enc_seq", 64'(bus_if.enc_seq), 64'(0));
        t_grant = -1000; t_done = -1000; done_at = -1;
        m_last = NREQ - 1; m_flags = '0; m_seq = '0; m_ack = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n++;
        end
        drive_inputs();
        rst_n = 1'b1;
        rel = n;
    endtask

    initial begin
        int unsigned exp_order [4] = '{1, 2, 4, 1};
        bit found;
        for (int i = 0; i < NREQ; i++) begin
            pflags[i] = '0; pseq[i] = '0; pack[i] = '0;
        end
        bus_if.enc_done = 1'b0;
        drive_inputs();
        apply_reset();

        // Single requester with known header fields
        pflags[0] = 8'h12; pseq[0] = 32'h1000; pack[0] = 32'h2000;
        pending = 3'b001;
        glog.delete();
        repeat (30) tick();
        check("s1_grant_count", 64'(glog.size() >= 1), 64'(1));
        if (glog.size() >= 1) check("s1_first_grant", 64'(glog[0]), 64'(1));

        // All three held: round-robin order with wrap
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            pflags[i] = 8'($urandom); pseq[i] = $urandom; pack[i] = $urandom;
        end
        glog.delete();
        for (int c = 0; c < 100; c++) begin
            pending = '1;
            tick();
        end
        check("s2_grant_count", 64'(glog.size() >= 4), 64'(1));
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) check("s2_order", 64'(glog[i]), 64'(exp_order[i]));

        // Encoder not ready: request waits, then is granted
        pending = '0;
        repeat (40) tick();
        glog.delete();
        ready_v = 1'b0;
        pending = 3'b010;
        repeat (20) tick();
        check("s3_no_grant", 64'(glog.size()), 64'(0));
        ready_v = 1'b1;
        repeat (3) tick();
        check("s3_grant_count", 64'(glog.size()), 64'(1));
        if (glog.size() >= 1) check("s3_grant", 64'(glog[0]), 64'(2));

        // Reset in the middle of RUN, then first grant goes to requester 0
        run_max = 40;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            pending = '1;
            tick();
            found = (t_done == INF) && (n > t_grant) && (done_at > n + 1);
        end
        check("s5_reached_run", 64'(found), 64'(1));
        run_max = 6;
        pending = '1;
        apply_reset();
        glog.delete();
        repeat (3) tick();
        check("s5_grant_count", 64'(glog.size()), 64'(1));
        if (glog.size() >= 1) check("s5_first_grant", 64'(glog[0]), 64'(1));

        // Randomized traffic with drops, encoder stalls and stray enc_done pulses
        stray_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 5) == 0) begin
                    pending[i] = 1'b1;
                    pflags[i] = 8'($urandom); pseq[i] = $urandom; pack[i] = $urandom;
                end else if (pending[i] && $urandom_range(0, 39) == 0) begin
                    pending[i] = 1'b0;
                end
            end
            ready_v = ($urandom_range(0, 7) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
